// File: rtl/cp0_regs.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_regs
//  Description : Coprocessor-0 register file. Takes per-register write
//                strobes from writeback, holds CP0 state, runs the
//                Count/Compare timer, samples hardware interrupts and raises
//                the interrupt request. Combinational MFC0 read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_regs #(
   parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
   parameter logic [31:0] PRID         = 32'h0001_8000,
   parameter int          COUNT_DIV    = 2,
   parameter int          TLB_BITS     = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Write0,
   input  logic [31:0] Write0Data,
   input  logic        Write2,
   input  logic [31:0] Write2Data,
   input  logic        Write3,
   input  logic [31:0] Write3Data,
   input  logic        Write8,
   input  logic [31:0] Write8Data,
   input  logic        Write10,
   input  logic [31:0] Write10Data,
   input  logic        Write11,
   input  logic [31:0] Write11Data,
   input  logic        Write12,
   input  logic [31:0] Write12Data,
   input  logic        Write13,
   input  logic [31:0] Write13Data,
   input  logic        Write14,
   input  logic [31:0] Write14Data,
   input  logic        Write15,
   input  logic [31:0] Write15Data,
   input  logic        Write18,
   input  logic [31:0] Write18Data,
   input  logic        Write19,
   input  logic [31:0] Write19Data,
   input  logic [5:0]  Int,
   input  logic [4:0]  ReadAddress,
   output logic [31:0] ReadData,
   output logic [31:0] IndexOut,
   output logic [31:0] EntryLo0Out,
   output logic [31:0] EntryLo1Out,
   output logic [31:0] EntryHiOut,
   output logic [31:0] StatusOut,
   output logic [31:0] CauseOut,
   output logic [31:0] EpcOut,
   output logic        TimerInterrupt,
   output logic        Interrupt
);

   // Writable-bit masks; bits outside a mask keep their (reset-zero) value.
   localparam logic [31:0] c_index_mask   = 32'h8000_0000 | ((32'h1 << TLB_BITS) - 32'h1);
   localparam logic [31:0] c_entrylo_mask = 32'h03FF_FFFF;
   localparam logic [31:0] c_entryhi_mask = 32'hFFFF_E0FF;
   localparam logic [31:0] c_cause_mask   = 32'h8000_037C;

   logic [31:0] r_index;
   logic [31:0] r_entrylo0;
   logic [31:0] r_entrylo1;
   logic [31:0] r_entryhi;
   logic [31:0] r_badvaddr;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic [31:0] r_status;
   logic [31:0] r_cause_sw;   // software-written Cause fields: BD, IP[9:8], ExcCode
   logic [31:0] r_epc;
   logic [31:0] r_watchlo;
   logic [31:0] r_watchhi;
   logic [5:0]  r_ip_hw;      // sampled hardware interrupt lines, Cause[15:10]
   logic        r_ti;
   logic        r_phase;

   logic        w_tick;
   logic [31:0] w_count_next;
   logic [31:0] w_cause;
   logic        w_unused;

   // PRId is a constant; its write port is accepted but has no effect.
   assign w_unused = Write15 ^ (^Write15Data);

   assign w_tick       = (COUNT_DIV == 1) ? 1'b1 : r_phase;
   assign w_count_next = r_count + 32'd1;

   // Live Cause view: stored software fields merged with sampled IP and TI.
   assign w_cause = r_cause_sw | {1'b0, r_ti, 14'b0, r_ip_hw, 10'b0};

   // TLB-facing registers with their field masks applied on write.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_index    <= 32'h0;
         r_entrylo0 <= 32'h0;
         r_entrylo1 <= 32'h0;
         r_entryhi  <= 32'h0;
      end else begin
         if (Write0)  r_index    <= (r_index    & ~c_index_mask)   | (Write0Data  & c_index_mask);
         if (Write2)  r_entrylo0 <= (r_entrylo0 & ~c_entrylo_mask) | (Write2Data  & c_entrylo_mask);
         if (Write3)  r_entrylo1 <= (r_entrylo1 & ~c_entrylo_mask) | (Write3Data  & c_entrylo_mask);
         if (Write10) r_entryhi  <= (r_entryhi  & ~c_entryhi_mask) | (Write10Data & c_entryhi_mask);
      end
   end

   // Exception-facing and watch registers; each strobe commits independently.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_badvaddr <= 32'h0;
         r_status   <= STATUS_RESET;
         r_cause_sw <= 32'h0;
         r_epc      <= 32'h0;
         r_watchlo  <= 32'h0;
         r_watchhi  <= 32'h0;
      end else begin
         if (Write8)  r_badvaddr <= Write8Data;
         if (Write12) r_status   <= Write12Data;
         if (Write13) r_cause_sw <= (r_cause_sw & ~c_cause_mask) | (Write13Data & c_cause_mask);
         if (Write14) r_epc      <= Write14Data;
         if (Write18) r_watchlo  <= Write18Data;
         if (Write19) r_watchhi  <= Write19Data;
      end
   end

   // Count/Compare timer, sticky TI, and hardware interrupt sampling.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase   <= 1'b0;
         r_count   <= 32'h0;
         r_compare <= 32'h0;
         r_ti      <= 1'b0;
         r_ip_hw   <= 6'h0;
      end else begin
         r_phase <= ~r_phase;
         if (w_tick) r_count <= w_count_next;
         if (Write11) r_compare <= Write11Data;
         // A Compare write acknowledges the timer and beats a same-cycle match.
         if (Write11)
            r_ti <= 1'b0;
         else if (w_tick && (w_count_next == r_compare))
            r_ti <= 1'b1;
         // IP7 is shared between Int[5] and the timer.
         r_ip_hw <= {Int[5] | r_ti, Int[4:0]};
      end
   end

   // MFC0 read multiplexer; unimplemented registers read as zero.
   always_comb begin
      ReadData = 32'h0;
      case (ReadAddress)
         5'd0:    ReadData = r_index;
         5'd2:    ReadData = r_entrylo0;
         5'd3:    ReadData = r_entrylo1;
         5'd8:    ReadData = r_badvaddr;
         5'd9:    ReadData = r_count;
         5'd10:   ReadData = r_entryhi;
         5'd11:   ReadData = r_compare;
         5'd12:   ReadData = r_status;
         5'd13:   ReadData = w_cause;
         5'd14:   ReadData = r_epc;
         5'd15:   ReadData = PRID;
         5'd18:   ReadData = r_watchlo;
         5'd19:   ReadData = r_watchhi;
         default: ReadData = 32'h0;
      endcase
   end

   assign IndexOut       = r_index;
   assign EntryLo0Out    = r_entrylo0;
   assign EntryLo1Out    = r_entrylo1;
   assign EntryHiOut     = r_entryhi;
   assign StatusOut      = r_status;
   assign CauseOut       = w_cause;
   assign EpcOut         = r_epc;
   assign TimerInterrupt = r_ti;

   // Request only when globally enabled and not already in exception/error level.
   assign Interrupt = r_status[0] & ~r_status[1] & ~r_status[2] &
                      (|(w_cause[15:8] & r_status[15:8]));

endmodule
`default_nettype wire

// File: tb/tb_cp0_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_regs
//  Description : Directed self-checking bench for cp0_regs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_regs;

   logic        clock = 1'b0;
   logic        reset;
   logic        Write0, Write2, Write3, Write8, Write10, Write11;
   logic        Write12, Write13, Write14, Write15, Write18, Write19;
   logic [31:0] Write0Data, Write2Data, Write3Data, Write8Data, Write10Data, Write11Data;
   logic [31:0] Write12Data, Write13Data, Write14Data, Write15Data, Write18Data, Write19Data;
   logic [5:0]  Int;
   logic [4:0]  ReadAddress;
   logic [31:0] ReadData;
   logic [31:0] IndexOut, EntryLo0Out, EntryLo1Out, EntryHiOut;
   logic [31:0] StatusOut, CauseOut, EpcOut;
   logic        TimerInterrupt, Interrupt;

   int checks   = 0;
   int failures = 0;

   cp0_regs dut (
      .clock(clock), .reset(reset),
      .Write0(Write0),   .Write0Data(Write0Data),
      .Write2(Write2),   .Write2Data(Write2Data),
      .Write3(Write3),   .Write3Data(Write3Data),
      .Write8(Write8),   .Write8Data(Write8Data),
      .Write10(Write10), .Write10Data(Write10Data),
      .Write11(Write11), .Write11Data(Write11Data),
      .Write12(Write12), .Write12Data(Write12Data),
      .Write13(Write13), .Write13Data(Write13Data),
      .Write14(Write14), .Write14Data(Write14Data),
      .Write15(Write15), .Write15Data(Write15Data),
      .Write18(Write18), .Write18Data(Write18Data),
      .Write19(Write19), .Write19Data(Write19Data),
      .Int(Int), .ReadAddress(ReadAddress), .ReadData(ReadData),
      .IndexOut(IndexOut), .EntryLo0Out(EntryLo0Out), .EntryLo1Out(EntryLo1Out),
      .EntryHiOut(EntryHiOut), .StatusOut(StatusOut), .CauseOut(CauseOut),
      .EpcOut(EpcOut), .TimerInterrupt(TimerInterrupt), .Interrupt(Interrupt)
   );

   always #5 clock = ~clock;

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      ReadAddress = addr;
      #1;
      chk(tag, ReadData, exp);
   endtask

   task automatic set_wr(input int n, input logic [31:0] d);
      case (n)
         0:  begin Write0  = 1'b1; Write0Data  = d; end
         2:  begin Write2  = 1'b1; Write2Data  = d; end
         3:  begin Write3  = 1'b1; Write3Data  = d; end
         8:  begin Write8  = 1'b1; Write8Data  = d; end
         10: begin Write10 = 1'b1; Write10Data = d; end
         11: begin Write11 = 1'b1; Write11Data = d; end
         12: begin Write12 = 1'b1; Write12Data = d; end
         13: begin Write13 = 1'b1; Write13Data = d; end
         14: begin Write14 = 1'b1; Write14Data = d; end
         15: begin Write15 = 1'b1; Write15Data = d; end
         18: begin Write18 = 1'b1; Write18Data = d; end
         19: begin Write19 = 1'b1; Write19Data = d; end
         default: ;
      endcase
   endtask

   task automatic clr_wr();
      {Write0, Write2, Write3, Write8, Write10, Write11} = 6'b0;
      {Write12, Write13, Write14, Write15, Write18, Write19} = 6'b0;
   endtask

   // Hold reset for n clocks, release at a falling edge with post-reset state visible.
   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   initial begin
      logic found;
      clr_wr();
      {Write0Data, Write2Data, Write3Data, Write8Data, Write10Data, Write11Data} = '0;
      {Write12Data, Write13Data, Write14Data, Write15Data, Write18Data, Write19Data} = '0;
      Int = 6'h0;
      ReadAddress = 5'd0;
      reset = 1'b1;
      @(negedge clock);
      do_reset(2);

      // ---- 1: reset in the middle of activity ----
      set_wr(12, 32'h0000_8001);
      set_wr(0, 32'h8000_0005);
      set_wr(11, 32'h0000_0004);
      tick();
      clr_wr();
      Int = 6'b000001;
      repeat (6) tick();
      Int = 6'h0;
      do_reset(3);
      chk("rst_status", StatusOut, 32'h0040_0000);
      chk("rst_cause", CauseOut, 32'h0);
      chk("rst_index", IndexOut, 32'h0);
      chk("rst_int", 32'(Interrupt), 32'h0);
      chk("rst_ti", 32'(TimerInterrupt), 32'h0);
      chk_rd("rst_count", 5'd9, 32'h0);
      chk_rd("rst_prid", 5'd15, 32'h0001_8000);
      chk_rd("rst_compare", 5'd11, 32'h0);

      // ---- 2: write masks, simultaneous strobes, no bypass ----
      set_wr(13, 32'hFFFF_FFFF);
      set_wr(10, 32'hFFFF_FFFF);
      set_wr(0, 32'hFFFF_FFFF);
      set_wr(2, 32'hFFFF_FFFF);
      set_wr(15, 32'h1234_5678);
      chk_rd("nobypass_cause", 5'd13, 32'h0);
      tick();
      clr_wr();
      chk("mask_cause", CauseOut, 32'h8000_037C);
      chk("mask_entryhi", EntryHiOut, 32'hFFFF_E0FF);
      chk("mask_index", IndexOut, 32'h8000_000F);
      chk("mask_entrylo0", EntryLo0Out, 32'h03FF_FFFF);
      chk("mask_entrylo1", EntryLo1Out, 32'h0);
      chk_rd("rd_cause", 5'd13, 32'h8000_037C);
      chk_rd("wr15_ignored", 5'd15, 32'h0001_8000);
      chk_rd("unimpl_rd", 5'd5, 32'h0);

      // ---- 3a: timer match at Count 4->5, sticky, cleared by Compare write ----
      do_reset(1);
      set_wr(11, 32'd5);
      tick();
      clr_wr();
      repeat (8) tick();
      chk("tmr_pre_ti", 32'(TimerInterrupt), 32'h0);
      chk_rd("tmr_pre_count", 5'd9, 32'd4);
      tick();
      chk("tmr_ti_rise", 32'(TimerInterrupt), 32'h1);
      chk_rd("tmr_count5", 5'd9, 32'd5);
      repeat (4) tick();
      chk("tmr_sticky", 32'(TimerInterrupt), 32'h1);
      chk("tmr_cause_ti_ip7", CauseOut, 32'h4000_8000);
      set_wr(11, 32'd5);
      tick();
      clr_wr();
      chk("tmr_wr11_clear", 32'(TimerInterrupt), 32'h0);
      chk("tmr_ip7_lag", CauseOut, 32'h0000_8000);

      // ---- 3b: Compare write coinciding with a match ----
      do_reset(1);
      set_wr(11, 32'd5);
      tick();
      clr_wr();
      repeat (8) tick();
      set_wr(11, 32'd7);
      tick();
      clr_wr();
      chk("tmr_collide_ti", 32'(TimerInterrupt), 32'h0);
      chk_rd("tmr_collide_cmp", 5'd11, 32'd7);
      chk_rd("tmr_collide_cnt", 5'd9, 32'd5);
      repeat (4) tick();
      chk("tmr_new_cmp_hit", 32'(TimerInterrupt), 32'h1);

      // ---- 4: interrupt request gating ----
      do_reset(1);
      set_wr(11, 32'd3);
      set_wr(12, 32'h0000_8001);
      tick();
      clr_wr();
      Int = 6'b100000;
      chk("irq_latency0", 32'(Interrupt), 32'h0);
      tick();
      chk("irq_raised", 32'(Interrupt), 32'h1);
      set_wr(12, 32'h0000_8003);
      tick();
      clr_wr();
      Int = 6'h0;
      chk("irq_exl_mask", 32'(Interrupt), 32'h0);
      repeat (4) tick();
      chk("irq_ti_set", 32'(TimerInterrupt), 32'h1);
      chk("irq_ip7_from_ti", CauseOut, 32'h4000_8000);
      chk("irq_still_masked", 32'(Interrupt), 32'h0);
      set_wr(12, 32'h0000_8001);
      tick();
      clr_wr();
      chk("irq_after_eret", 32'(Interrupt), 32'h1);

      // ---- 5: exception-entry burst ----
      do_reset(1);
      set_wr(14, 32'hBFC0_0100);
      set_wr(12, 32'h0000_8003);
      set_wr(13, 32'h8000_0010);
      set_wr(8, 32'hDEAD_BEEF);
      chk_rd("exc_nobypass", 5'd8, 32'h0);
      tick();
      clr_wr();
      chk("exc_epc", EpcOut, 32'hBFC0_0100);
      chk("exc_status", StatusOut, 32'h0000_8003);
      chk("exc_cause", CauseOut, 32'h8000_0010);
      chk_rd("exc_badvaddr", 5'd8, 32'hDEAD_BEEF);
      chk_rd("exc_rd_epc", 5'd14, 32'hBFC0_0100);

      // ---- 6: Count wrap matches Compare=0 ----
      do_reset(1);
      force dut.r_count = 32'hFFFF_FFFD;
      repeat (2) tick();
      release dut.r_count;
      chk("wrap_pre_ti", 32'(TimerInterrupt), 32'h0);
      ReadAddress = 5'd9;
      #1;
      chk("wrap_pre_count", ReadData & 32'hFFFF_FFF0, 32'hFFFF_FFF0);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         if (TimerInterrupt === 1'b1) found = 1'b1;
      end
      chk("wrap_ti_seen", 32'(found), 32'h1);
      chk_rd("wrap_count_zero", 5'd9, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
